calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Controller that sequences the calculator ALU datapath. It collects operand and operator tokens from the input decoder (number-entry and operator strobes), loads the ALU operands and operation code, and issues a start pulse.
- It waits on the ALU completion handshake, then returns the registered result and flags to the display path.
- It supports chained operations (`a op b op c ... =`) by feeding each result back as the next A operand.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, operation code width.
- OP_MAX, 9, highest legal op_code; codes above it are illegal.
- ALU_TIMEOUT, 15, max cycles waited for alu_done after alu_start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- num_valid  in  1  one-cycle strobe: num_data is a completed operand.
- num_data  in  DATA_W  operand value.
- op_valid  in  1  one-cycle strobe: op_code is an operator key.
- op_code  in  OP_W  operator code.
- eq_valid  in  1  one-cycle strobe: equals key.
- clear  in  1  one-cycle strobe: abort and clear.
- alu_a  out  DATA_W  ALU operand A (registered).
- alu_b  out  DATA_W  ALU operand B (registered).
- alu_op  out  OP_W  ALU operation (registered).
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU result valid strobe.
- alu_result  in  DATA_W  ALU result.
- alu_flags  in  4  NZCV from ALU.
- result  out  DATA_W  last completed result.
- flags  out  4  NZCV of last result.
- result_valid  out  1  one-cycle pulse when result/flags update.
- busy  out  1  high in EXEC/WAIT/DONE; input strobes are ignored while high.
- err  out  1  sticky error (illegal op or timeout); cleared by clear or reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - alu_a, alu_b, alu_op, result, flags = 0.
  - alu_start, result_valid, busy, err = 0.
  - chain flag=0, timeout counter=0.
- Input priority when not busy, same cycle: clear > eq_valid > op_valid > num_valid. Only the highest-priority strobe is consumed.
- clear is honoured in every state, including busy states. It forces IDLE next cycle, deasserts alu_start, and zeroes err. result/flags are kept. Any alu_done arriving after clear is ignored.
- States:
  - IDLE: num_valid → alu_a=num_data, go HAVE_A. op_valid → alu_a=result, latch op, go HAVE_OP (uses prior result as A). eq ignored.
  - HAVE_A: num_valid overwrites alu_a. Legal op_valid → alu_op=op_code, go HAVE_OP. eq ignored.
  - HAVE_OP: legal op_valid overwrites alu_op. num_valid → alu_b=num_data, go HAVE_B. eq ignored.
  - HAVE_B: num_valid overwrites alu_b. eq_valid → chain=0, go EXEC. Legal op_valid → pend_op=op_code, chain=1, go EXEC.
  - EXEC: alu_start=1 for exactly this cycle; counter=0; go WAIT.
  - WAIT: on alu_done, register result=alu_result and flags=alu_flags, go DONE. Otherwise increment counter; at counter==ALU_TIMEOUT set err=1 and go IDLE with no result_valid.
  - DONE: result_valid=1 for exactly this cycle; alu_a=result. If chain: alu_op=pend_op, go HAVE_OP; else go IDLE.
- Illegal op_code (>OP_MAX) with op_valid: err=1, token dropped, state unchanged.
- Latency: eq_valid accepted at edge N gives alu_start high during cycle N+1. alu_done sampled at edge M gives result_valid high during cycle M+1, with result stable from that cycle.
- alu_done outside WAIT is ignored.
- Operands pass unmodified at DATA_W bits; no arithmetic is done in this block.

Test Plan:
- Basic add: num 7, op 1, num 5, eq; ALU model returns 12 two cycles after start → alu_a=7, alu_b=5, alu_op=1, a single alu_start pulse, result=12, result_valid one cycle, back to IDLE.
- Chain: 3, op 1, 4, op 2 (ALU returns 7), then 2, eq (ALU returns 14) → two alu_start pulses; second issue has alu_a=7, alu_b=2, alu_op=2; result_valid pulses twice; final result=14.
- Timeout: 1, op 1, 1, eq with alu_done never asserted → err=1 exactly ALU_TIMEOUT cycles after WAIT entry; state IDLE; no result_valid. Then clear → err=0.
- Clear mid-op: clear asserted in WAIT, alu_done arrives 2 cycles later → no result_valid; result unchanged; next sequence 2, op 1, 2, eq computes normally.
- Priority/illegal: num_valid and op_valid together in HAVE_A → only op consumed, alu_a unchanged. op_code=15 → err=1, state unchanged. Strobes while busy are ignored.
- Reset mid-operation: rst_n low during WAIT → all outputs 0 immediately (asynchronous), state IDLE after release, late alu_done ignored.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Calculator ALU sequencer: gathers operand/operator tokens, issues ALU operations,
// waits on the ALU handshake and returns results, chaining results into the next A.
module calc_op_sequencer #(
   parameter int DATA_W      = 32,
   parameter int OP_W        = 4,
   parameter int OP_MAX      = 9,
   parameter int ALU_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              num_valid,
   input  logic [DATA_W-1:0] num_data,
   input  logic              op_valid,
   input  logic [OP_W-1:0]   op_code,
   input  logic              eq_valid,
   input  logic              clear,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags,
   output logic              result_valid,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
   localparam logic [OP_W-1:0]  OP_MAX_V  = OP_W'(OP_MAX);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(ALU_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HAVE_A  = 3'd1,
      S_HAVE_OP = 3'd2,
      S_HAVE_B  = 3'd3,
      S_EXEC    = 3'd4,
      S_WAIT    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [OP_W-1:0]     alu_op_q, alu_op_d, pend_op_q, pend_op_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [3:0]          flags_q, flags_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                chain_q, chain_d;
   logic                alu_start_q, alu_start_d;
   logic                result_valid_q, result_valid_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                op_legal_s, take_eq_s, take_op_s, take_num_s;
   logic [CNT_W-1:0]    cnt_inc_s;

   // Only the highest-priority strobe is considered; clear is handled above all.
   assign take_eq_s  = eq_valid;
   assign take_op_s  = op_valid & ~eq_valid;
   assign take_num_s = num_valid & ~eq_valid & ~op_valid;
   assign op_legal_s = (op_code <= OP_MAX_V);
   assign cnt_inc_s  = cnt_q + CNT_ONE;

   // Next-state and next-output computation.
   always_comb begin
      state_d        = state_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      alu_op_d       = alu_op_q;
      pend_op_d      = pend_op_q;
      result_d       = result_q;
      flags_d        = flags_q;
      cnt_d          = cnt_q;
      chain_d        = chain_q;
      err_d          = err_q;
      if (clear) begin
         state_d = S_IDLE;
         chain_d = 1'b0;
         cnt_d   = {CNT_W{1'b0}};
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (take_op_s) begin
                  if (op_legal_s) begin
                     alu_a_d  = result_q;
                     alu_op_d = op_code;
                     state_d  = S_HAVE_OP;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (take_num_s) begin
                  alu_a_d = num_data;
                  state_d = S_HAVE_A;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_HAVE_A: begin
               if (take_op_s) begin
                  if (op_legal_s) begin
                     alu_op_d = op_code;
                     state_d  = S_HAVE_OP;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (take_num_s) begin
                  alu_a_d = num_data;
               end else begin
                  state_d = S_HAVE_A;
               end
            end
            S_HAVE_OP: begin
               if (take_op_s) begin
                  if (op_legal_s) begin
                     alu_op_d = op_code;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (take_num_s) begin
                  alu_b_d = num_data;
                  state_d = S_HAVE_B;
               end else begin
                  state_d = S_HAVE_OP;
               end
            end
            S_HAVE_B: begin
               if (take_eq_s) begin
                  chain_d = 1'b0;
                  state_d = S_EXEC;
               end else if (take_op_s) begin
                  if (op_legal_s) begin
                     pend_op_d = op_code;
                     chain_d   = 1'b1;
                     state_d   = S_EXEC;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (take_num_s) begin
                  alu_b_d = num_data;
               end else begin
                  state_d = S_HAVE_B;
               end
            end
            S_EXEC: begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (alu_done) begin
                  result_d = alu_result;
                  flags_d  = alu_flags;
                  state_d  = S_DONE;
               end else if (cnt_inc_s == TIMEOUT_V) begin
                  cnt_d   = {CNT_W{1'b0}};
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            S_DONE: begin
               alu_a_d = result_q;
               if (chain_q) begin
                  alu_op_d = pend_op_q;
                  chain_d  = 1'b0;
                  state_d  = S_HAVE_OP;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      // Pulse/level outputs are registered from the state being entered.
      alu_start_d    = (state_d == S_EXEC);
      result_valid_d = (state_d == S_DONE);
      busy_d         = (state_d == S_EXEC) || (state_d == S_WAIT) || (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         alu_a_q        <= {DATA_W{1'b0}};
         alu_b_q        <= {DATA_W{1'b0}};
         alu_op_q       <= {OP_W{1'b0}};
         pend_op_q      <= {OP_W{1'b0}};
         result_q       <= {DATA_W{1'b0}};
         flags_q        <= 4'd0;
         cnt_q          <= {CNT_W{1'b0}};
         chain_q        <= 1'b0;
         alu_start_q    <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_op_q       <= alu_op_d;
         pend_op_q      <= pend_op_d;
         result_q       <= result_d;
         flags_q        <= flags_d;
         cnt_q          <= cnt_d;
         chain_q        <= chain_d;
         alu_start_q    <= alu_start_d;
         result_valid_q <= result_valid_d;
         busy_q         <= busy_d;
         err_q          <= err_d;
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign alu_start    = alu_start_q;
   assign result       = result_q;
   assign flags        = flags_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: token-level calculator model predicts
// ALU issues and results; a negedge monitor pops and compares them.
module tb_calc_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        num_valid = 1'b0, op_valid = 1'b0, eq_valid = 1'b0, clear = 1'b0;
   logic [31:0] num_data = 32'd0;
   logic [3:0]  op_code = 4'd0;
   logic [31:0] alu_a, alu_b, alu_result, result;
   logic [3:0]  alu_op, alu_flags, flags;
   logic        alu_start, alu_done, result_valid, busy, err;

   typedef struct packed { logic [31:0] a; logic [31:0] b; logic [3:0] op; } issue_t;
   typedef struct packed { logic [31:0] r; logic [3:0] f; } res_t;
   issue_t iss_q[$];
   res_t   res_q[$];

   int          n_vec = 0, n_err = 0;
   int          alu_delay = 2;
   bit          alu_enable = 1'b1;
   logic [31:0] m_result = 32'd0;

   calc_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .num_valid(num_valid), .num_data(num_data),
      .op_valid(op_valid), .op_code(op_code), .eq_valid(eq_valid), .clear(clear),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
      .result(result), .flags(flags), .result_valid(result_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a * b;
         4'd3:    return a - b;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         4'd7:    return a << b[4:0];
         4'd8:    return a >> b[4:0];
         4'd9:    return b;
         default: return a;
      endcase
   endfunction

   function automatic logic [3:0] flg_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      logic [31:0] r;
      r = alu_fn(a, b, op);
      return {r[31], (r == 32'd0), a[0] ^ b[0], op[0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic flag_unexpected(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: observed pulse, required none", name);
   endtask

   // Expected ALU issue; when the ALU answers, the result becomes the model's last result.
   task automatic expect_issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input bit completes);
      iss_q.push_back('{a: a, b: b, op: op});
      if (completes) begin
         res_q.push_back('{r: alu_fn(a, b, op), f: flg_fn(a, b, op)});
         m_result = alu_fn(a, b, op);
      end
   endtask

   task automatic pulse(input logic nv, input logic [31:0] nd, input logic ov, input logic [3:0] oc,
                        input logic ev, input logic cv);
      @(posedge clk); #1;
      num_valid = nv; num_data = nd; op_valid = ov; op_code = oc; eq_valid = ev; clear = cv;
      @(posedge clk); #1;
      num_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic send_num(input logic [31:0] d); pulse(1'b1, d, 1'b0, 4'd0, 1'b0, 1'b0); endtask
   task automatic send_op(input logic [3:0] o);   pulse(1'b0, 32'd0, 1'b1, o, 1'b0, 1'b0); endtask
   task automatic send_eq();                      pulse(1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0); endtask
   task automatic send_clear();                   pulse(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1); endtask

   task automatic wait_not_busy();
      int k = 0;
      while (busy && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("busy_release", busy, 1'b0);
   endtask

   // ALU model: answers each start after alu_delay negedges.
   initial begin
      logic [31:0] a, b;
      logic [3:0]  op;
      alu_done = 1'b0; alu_result = 32'd0; alu_flags = 4'd0;
      forever begin
         @(negedge clk);
         if (alu_start && alu_enable) begin
            a = alu_a; b = alu_b; op = alu_op;
            repeat (alu_delay) @(negedge clk);
            alu_done = 1'b1; alu_result = alu_fn(a, b, op); alu_flags = flg_fn(a, b, op);
            @(negedge clk);
            alu_done = 1'b0; alu_result = 32'd0; alu_flags = 4'd0;
         end
      end
   end

   // Monitor: compares every ALU issue and every result pulse against the scoreboard.
   initial begin
      issue_t ei;
      res_t   er;
      forever begin
         @(negedge clk);
         if (rst_n && alu_start) begin
            if (iss_q.size() == 0) flag_unexpected("alu_start_unexpected");
            else begin
               ei = iss_q.pop_front();
               check("issue_a", alu_a, ei.a);
               check("issue_b", alu_b, ei.b);
               check("issue_op", alu_op, ei.op);
            end
         end
         if (rst_n && result_valid) begin
            if (res_q.size() == 0) flag_unexpected("result_valid_unexpected");
            else begin
               er = res_q.pop_front();
               check("result", result, er.r);
               check("flags", flags, er.f);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_random_expr();
      logic [31:0] a, b;
      logic [3:0]  op, nop;
      int          nops;
      logic        err_exp;
      err_exp = 1'b0;
      nop = 4'd0;
      nops = $urandom_range(1, 3);
      alu_delay = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) a = m_result;
      else begin
         a = $urandom; send_num(a);
         if ($urandom_range(0, 2) == 0) begin
            send_eq();
            a = $urandom; send_num(a);
         end
      end
      if ($urandom_range(0, 3) == 0) begin
         send_op(4'($urandom_range(10, 15)));
         err_exp = 1'b1;
      end
      op = 4'($urandom_range(0, 9));
      send_op(op);
      for (int k = 0; k < nops; k++) begin
         b = $urandom; send_num(b);
         if ($urandom_range(0, 2) == 0) begin
            b = $urandom; send_num(b);
         end
         if (k == nops - 1) send_eq();
         else begin
            nop = 4'($urandom_range(0, 9));
            send_op(nop);
         end
         expect_issue(a, b, op, 1'b1);
         a = m_result;
         op = nop;
         if ($urandom_range(0, 1) == 0) send_num($urandom);
         wait_not_busy();
      end
      check("err_sticky", err, err_exp);
      if (err_exp) send_clear();
   endtask

   initial begin
      logic [31:0] prev;
      repeat (3) @(posedge clk);
      #1;
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_op", alu_op, 4'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", flags, 4'd0);
      check("rst_ctrl", {alu_start, result_valid, busy, err}, 4'b0000);
      @(negedge clk); rst_n = 1'b1;

      // Basic add, then an eq in IDLE must not issue anything.
      alu_delay = 2;
      send_num(32'd7); send_op(4'd1); send_num(32'd5); send_eq();
      expect_issue(32'd7, 32'd5, 4'd1, 1'b1);
      wait_not_busy();
      check("add_result", result, 32'd12);
      send_eq();
      repeat (4) @(posedge clk);

      // Chain: (3 + 4) * 2.
      send_num(32'd3); send_op(4'd1); send_num(32'd4); send_op(4'd2);
      expect_issue(32'd3, 32'd4, 4'd1, 1'b1);
      wait_not_busy();
      send_num(32'd2); send_eq();
      expect_issue(32'd7, 32'd2, 4'd2, 1'b1);
      wait_not_busy();
      check("chain_result", result, 32'd14);

      // Timeout: err exactly 15 cycles after WAIT entry, then clear.
      alu_enable = 1'b0;
      send_num(32'd1); send_op(4'd1); send_num(32'd1); send_eq();
      expect_issue(32'd1, 32'd1, 4'd1, 1'b0);
      @(posedge clk); #1;
      repeat (14) @(posedge clk);
      #1;
      check("err_before_timeout", {busy, err}, 2'b10);
      @(posedge clk); #1;
      check("err_at_timeout", {busy, err}, 2'b01);
      check("timeout_result_kept", result, 32'd14);
      alu_enable = 1'b1;
      send_clear();
      check("err_cleared", err, 1'b0);

      // Clear during WAIT; the late alu_done must be ignored.
      alu_delay = 4;
      prev = m_result;
      send_num(32'd9); send_op(4'd1); send_num(32'd9); send_eq();
      expect_issue(32'd9, 32'd9, 4'd1, 1'b0);
      send_clear();
      check("clear_busy", busy, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check("clear_result_kept", result, prev);
      alu_delay = 2;
      send_num(32'd2); send_op(4'd1); send_num(32'd2); send_eq();
      expect_issue(32'd2, 32'd2, 4'd1, 1'b1);
      wait_not_busy();
      check("after_clear_result", result, 32'd4);

      // Priority, illegal op, eq beating op, strobes while busy.
      alu_delay = 3;
      send_num(32'd11);
      pulse(1'b1, 32'd99, 1'b1, 4'd3, 1'b0, 1'b0);
      check("prio_alu_a", alu_a, 32'd11);
      send_op(4'd15);
      check("illegal_err", err, 1'b1);
      send_num(32'd6);
      pulse(1'b0, 32'd0, 1'b1, 4'd4, 1'b1, 1'b0);
      expect_issue(32'd11, 32'd6, 4'd3, 1'b1);
      send_num(32'd77); send_op(4'd2);
      wait_not_busy();
      send_num(32'd8); send_eq();
      check("err_still_set", err, 1'b1);
      send_clear();
      check("err_clear2", err, 1'b0);

      // Asynchronous reset during WAIT.
      alu_delay = 5;
      send_num(32'd5); send_op(4'd1); send_num(32'd5); send_eq();
      expect_issue(32'd5, 32'd5, 4'd1, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_data", {alu_a, alu_b, alu_op, result[27:0]}, 64'd0);
      check("async_rst_ctrl", {result[31:28], flags, alu_start, result_valid, busy, err}, 12'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      m_result = 32'd0;
      repeat (8) @(posedge clk);
      #1;
      check("post_rst_result", result, 32'd0);
      check("post_rst_busy", busy, 1'b0);

      for (int e = 0; e < 20; e++) run_random_expr();

      repeat (10) @(posedge clk);
      #1;
      check("issue_q_drained", iss_q.size(), 0);
      check("res_q_drained", res_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
